hunt_round_ctl: RTL



---
 rtl/hunt_round_ctl_pkg.sv | 42 ++++
 rtl/hunt_round_ctl_frame_timer.sv | 43 ++++
 rtl/hunt_round_ctl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hunt_round_ctl_pkg.sv
// ============================================================================
//  Module      : hunt_round_ctl_pkg
//  Description : Shared state encoding, game defaults and fly-limit helper
//                for the Duck Hunt round controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hunt_round_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        FLY    = 3'd2,
        HIT    = 3'd3,
        ESCAPE = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } hunt_state_t;

    localparam int HUNT_TOTAL_DUCKS  = 10;
    localparam int HUNT_FLY_FRAMES   = 300;
    localparam int HUNT_PAUSE_FRAMES = 60;
    localparam int HUNT_PASS_HITS    = 6;

    localparam int HUNT_RAMP_STEP    = 16;
    localparam int HUNT_RAMP_MIN     = 32;

    // Later ducks fly for a shorter time, but never below HUNT_RAMP_MIN frames.
    function automatic logic [9:0] hunt_ramp_limit(input int fly_frames,
                                                   input logic [3:0] idx);
        int lim;
        lim = fly_frames - HUNT_RAMP_STEP * int'(idx);
        if (lim < HUNT_RAMP_MIN) begin
            lim = HUNT_RAMP_MIN;
        end
        return lim[9:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/hunt_round_ctl_frame_timer.sv
// ============================================================================
//  Module      : hunt_round_ctl_frame_timer
//  Description : 10-bit frame counter with synchronous clear; done flags
//                count == limit and the counter holds there.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hunt_round_ctl_frame_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic [9:0] limit,
    output logic       done
);

    logic [9:0] count_d;
    logic [9:0] count_q;

    assign done = (count_q == limit);

    // A tick arriving together with a clear is dropped on purpose.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (frame_tick && !done) begin
            count_d = count_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hunt_round_ctl.sv
// ============================================================================
//  Module      : hunt_round_ctl
//  Description : Sequences one Duck Hunt game: arm, fly, hit/escape, next duck,
//                and reports the final score. Optional per-duck fly-time ramp
//                is enabled with HUNT_DIFFICULTY_RAMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hunt_round_ctl
    import hunt_round_ctl_pkg::*;
#(
    parameter int TOTAL_DUCKS  = HUNT_TOTAL_DUCKS,
    parameter int FLY_FRAMES   = HUNT_FLY_FRAMES,
    parameter int PAUSE_FRAMES = HUNT_PAUSE_FRAMES,
    parameter int PASS_HITS    = HUNT_PASS_HITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_enable,
    input  logic       frame_tick,
    input  logic       duck_hit,
    input  logic       out_of_bullets,
    output logic       hunt_start,
    output logic [3:0] duck_index,
    output logic [3:0] hit_count,
    output logic       duck_escaped,
    output logic       game_finished,
    output logic       round_passed
);

    localparam logic [9:0] C_PAUSE_LIMIT = 10'(PAUSE_FRAMES);
    localparam logic [3:0] C_LAST_IDX    = 4'(TOTAL_DUCKS - 1);
    localparam logic [4:0] C_PASS_HITS   = 5'(PASS_HITS);

    hunt_state_t state_d, state_q;

    logic [3:0] duck_index_d,    duck_index_q;
    logic [3:0] hit_count_d,     hit_count_q;
    logic       hunt_start_d,    hunt_start_q;
    logic       duck_escaped_d,  duck_escaped_q;
    logic       game_finished_d, game_finished_q;
    logic       round_passed_d,  round_passed_q;

    logic       timer_clear;
    logic       timer_done;
    logic [9:0] timer_limit;
    logic [9:0] fly_limit;

`ifdef HUNT_DIFFICULTY_RAMP_EN
    logic [9:0] fly_limit_d, fly_limit_q;

    // Latched on ARM entry so the limit is stable for the whole ARM/FLY span.
    always_comb begin
        fly_limit_d = fly_limit_q;
        if ((state_d == ARM) && (state_q != ARM)) begin
            fly_limit_d = hunt_ramp_limit(FLY_FRAMES, duck_index_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fly_limit_q <= hunt_ramp_limit(FLY_FRAMES, 4'd0);
        end else begin
            fly_limit_q <= fly_limit_d;
        end
    end

    assign fly_limit = fly_limit_q;
`else
    localparam logic [9:0] C_FLY_LIMIT = 10'(FLY_FRAMES);

    assign fly_limit = C_FLY_LIMIT;
`endif

    assign timer_limit = (state_q == FLY) ? fly_limit : C_PAUSE_LIMIT;
    assign timer_clear = (state_d != state_q);

    hunt_round_ctl_frame_timer u_frame_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (timer_clear),
        .frame_tick (frame_tick),
        .limit      (timer_limit),
        .done       (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        duck_index_d = duck_index_q;
        hit_count_d  = hit_count_q;

        // Score and index survive a drop to IDLE; they clear only on a new game.
        if (!game_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = ARM;
                    duck_index_d = '0;
                    hit_count_d  = '0;
                end
                ARM: begin
                    if (timer_done) begin
                        state_d = FLY;
                    end
                end
                FLY: begin
                    if (duck_hit) begin
                        state_d     = HIT;
                        hit_count_d = (hit_count_q == 4'hF) ? 4'hF : hit_count_q + 4'd1;
                    end else if (timer_done || out_of_bullets) begin
                        state_d = ESCAPE;
                    end
                end
                HIT, ESCAPE: begin
                    if (timer_done) begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (duck_index_q == C_LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d      = ARM;
                        duck_index_d = duck_index_q + 4'd1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        hunt_start_d    = (state_d == FLY);
        duck_escaped_d  = (state_d == ESCAPE) && (state_q != ESCAPE);
        game_finished_d = (state_d == DONE);
        round_passed_d  = (state_d == DONE) && ({1'b0, hit_count_d} >= C_PASS_HITS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            duck_index_q    <= '0;
            hit_count_q     <= '0;
            hunt_start_q    <= 1'b0;
            duck_escaped_q  <= 1'b0;
            game_finished_q <= 1'b0;
            round_passed_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            duck_index_q    <= duck_index_d;
            hit_count_q     <= hit_count_d;
            hunt_start_q    <= hunt_start_d;
            duck_escaped_q  <= duck_escaped_d;
            game_finished_q <= game_finished_d;
            round_passed_q  <= round_passed_d;
        end
    end

    assign hunt_start    = hunt_start_q;
    assign duck_index    = duck_index_q;
    assign hit_count     = hit_count_q;
    assign duck_escaped  = duck_escaped_q;
    assign game_finished = game_finished_q;
    assign round_passed  = round_passed_q;

endmodule

`default_nettype wire
